// File: rtl/ring_stop_judge.sv
// ring_stop_judge
// Game-control stage for the "stop the light" reaction game. It drives the
// shift enable of an external one-hot ring counter from a programmable
// prescaler. It debounces the player button and, on a press, captures the
// ring position and judges it against a target bit. It also keeps score and
// lives, and each hit shortens the rotation period.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle start pulse (honoured in IDLE and OVER)
//   btn        in   raw asynchronous player button, active-high
//   count      in   [W]  one-hot position from the ring counter
//   ring_en    out  one-cycle shift enable to the ring counter
//   hit        out  one-cycle pulse after a judged hit
//   miss       out  one-cycle pulse after a judged miss
//   score      out  [SCORE_W] current score (saturating)
//   lives      out  [3] remaining lives
//   game_over  out  high while in OVER
//   busy       out  high in RUN, JUDGE or HOLD
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | light rotating, waiting for a debounced press
// JUDGE | one cycle, evaluates the captured position
// HOLD  | pause after a miss, presses discarded
// OVER  | no lives left, waiting for start
module ring_stop_judge #(
    parameter int W           = 15,
    parameter int TARGET      = 7,
    parameter int DIV_INIT    = 5000000,
    parameter int DIV_STEP    = 500000,
    parameter int DIV_MIN     = 1000000,
    parameter int DB_CYCLES   = 200000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int LIVES       = 3,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               btn,
    input  logic [W-1:0]       count,
    output logic               ring_en,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic               busy
);

    localparam int DIV_W  = $clog2(DIV_INIT + 1);
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_INIT_V = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0]  DIV_STEP_V = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0]  DIV_MIN_V  = DIV_W'(DIV_MIN);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]        LIVES_V    = 3'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_JUDGE,
        S_HOLD,
        S_OVER
    } state_t;

    state_t              state_q;
    logic                sync1_q;
    logic                sync2_q;
    logic                db_level_q;
    logic [DB_W-1:0]     db_cnt_q;
    logic                press_q;
    logic [DIV_W-1:0]    presc_q;
    logic [DIV_W-1:0]    div_q;
    logic [W-1:0]        cap_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [SCORE_W-1:0]  score_q;
    logic [2:0]          lives_q;
    logic                hit_q;
    logic                miss_q;

    logic                presc_tc_d;
    logic                cap_hit_d;
    logic [DIV_W-1:0]    div_next_d;
    logic [SCORE_W-1:0]  score_next_d;

    // Button path: two-flop synchroniser, then a stability counter. The
    // counter only advances while the synchronised value disagrees with the
    // current level, so any bounce back to the old level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_level_q <= sync2_q;
                db_cnt_q   <= '0;
                press_q    <= sync2_q;   // rising edges only
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign presc_tc_d = (presc_q == div_q - DIV_W'(1));

    // A press on the terminal count holds the ring still, so the captured
    // position is the one the player actually saw.
    assign ring_en = (state_q == S_RUN) && presc_tc_d && !press_q;

    // Exactly one-hot and on the target bit; zero or multi-bit captures miss.
    assign cap_hit_d = (cap_q != '0) && ((cap_q & (cap_q - W'(1))) == '0) && cap_q[TARGET];

    // Compare in 32 bits so the floor is applied before any subtraction can wrap.
    always_comb begin
        div_next_d = DIV_MIN_V;
        if ({{(32 - DIV_W){1'b0}}, div_q} >= 32'(DIV_MIN + DIV_STEP)) begin
            div_next_d = div_q - DIV_STEP_V;
        end
    end

    assign score_next_d = (&score_q) ? score_q : score_q + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            div_q   <= DIV_INIT_V;
            cap_q   <= '0;
            hold_q  <= '0;
            score_q <= '0;
            lives_q <= LIVES_V;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        div_q   <= DIV_INIT_V;
                        score_q <= '0;
                        lives_q <= LIVES_V;
                        presc_q <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (press_q) begin
                        cap_q   <= count;
                        state_q <= S_JUDGE;
                    end else if (presc_tc_d) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + DIV_W'(1);
                    end
                end
                S_JUDGE: begin
                    if (cap_hit_d) begin
                        hit_q   <= 1'b1;
                        score_q <= score_next_d;
                        div_q   <= div_next_d;
                        presc_q <= '0;
                        state_q <= S_RUN;
                    end else begin
                        miss_q  <= 1'b1;
                        lives_q <= lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_q <= S_OVER;
                        end else begin
                            hold_q  <= HOLD_LAST;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        presc_q <= '0;
                        state_q <= S_RUN;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = (state_q == S_OVER);
    assign busy      = (state_q == S_RUN) || (state_q == S_JUDGE) || (state_q == S_HOLD);

endmodule

// File: tb/tb_ring_stop_judge.sv
module tb_ring_stop_judge;

    localparam int W           = 15;
    localparam int TARGET      = 7;
    localparam int DIV_INIT    = 4;
    localparam int DIV_STEP    = 1;
    localparam int DIV_MIN     = 2;
    localparam int DB_CYCLES   = 3;
    localparam int HOLD_CYCLES = 5;
    localparam int LIVES       = 3;
    localparam int SCORE_W     = 8;
    localparam int LAT         = DB_CYCLES + 2;   // btn rise -> press cycle

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               btn = 1'b0;
    logic [W-1:0]       count;
    logic               ring_en, hit, miss, game_over, busy;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;

    logic [W-1:0]       ring_q;
    logic               inject = 1'b0;
    logic [W-1:0]       inj_val = '0;

    assign count = inject ? inj_val : ring_q;

    ring_stop_judge #(
        .W(W), .TARGET(TARGET), .DIV_INIT(DIV_INIT), .DIV_STEP(DIV_STEP),
        .DIV_MIN(DIV_MIN), .DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
        .LIVES(LIVES), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .count(count),
        .ring_en(ring_en), .hit(hit), .miss(miss), .score(score),
        .lives(lives), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Ring counter model, rotating right on each enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ring_q <= 15'h4000;
        else if (ring_en) ring_q <= {ring_q[0], ring_q[W-1:1]};
    end

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cur_d  = DIV_INIT;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] cnt;
        bit           inj;
        bit           exp_hit;
        int           exp_score;
        int           exp_lives;
        int           exp_d;
        bit           resume;
    } vec_t;

    typedef struct {
        bit h;
        int s;
        int l;
        int row;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];
    exp_t mon_e;

    // Scoreboard side: every hit/miss pulse must match the oldest pending row.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (hit === 1'b1 || miss === 1'b1)) begin
            pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_judge: hit=%0b miss=%0b with nothing pending", hit, miss);
            end else begin
                mon_e = sb_q.pop_front();
                chk($sformatf("row%0d_hit", mon_e.row), hit, mon_e.h);
                chk($sformatf("row%0d_miss", mon_e.row), miss, !mon_e.h);
                chk($sformatf("row%0d_score", mon_e.row), score, mon_e.s);
                chk($sformatf("row%0d_lives", mon_e.row), lives, mon_e.l);
            end
        end
    end

    // From the current negedge (index 0): ring_en low until index gap, high there,
    // then high again exactly d cycles later.
    task automatic check_resume(input string nm, input int gap, input int d);
        int bad = 0;
        for (int k = 0; k <= gap + d; k++) begin
            if (k > 0) @(negedge clk);
            if (ring_en !== ((k == gap) || (k == gap + d))) bad++;
        end
        chk(nm, bad, 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_row(input int i);
        vec_t         v;
        int           p;
        int           gap;
        logic [W-1:0] pre;
        logic [W-1:0] prev;
        bit           found;
        v = vecs[i];
        if (!v.inj) begin
            // Arm p positions early so the press cycle lands inside the target window.
            p = 1;
            while (p < 16 && !(p * cur_d <= LAT && (p + 1) * cur_d >= LAT + 1)) p++;
            pre = v.cnt;
            repeat (p) pre = {pre[W-2:0], pre[W-1]};
            prev = count;
            found = 1'b0;
            for (int t = 0; t < 400 && !found; t++) begin
                @(negedge clk);
                if (count == pre && prev != pre) found = 1'b1;
                prev = count;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL row%0d_align: position %0h never reached", i, pre);
                return;
            end
        end else begin
            repeat (8) @(negedge clk);
            inject  = 1'b1;
            inj_val = v.cnt;
        end
        btn = 1'b1;
        sb_q.push_back('{v.exp_hit, v.exp_score, v.exp_lives, i});
        fork
            begin
                repeat (10) @(negedge clk);
                btn = 1'b0;
            end
        join_none
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == LAT && !v.inj) chk($sformatf("row%0d_cap_pos", i), count, v.cnt);
            if (k == LAT + 1) begin
                if (!v.inj) chk($sformatf("row%0d_no_shift", i), count, v.cnt);
                chk($sformatf("row%0d_early_pulse", i), hit | miss, 0);
                inject = 1'b0;
            end
            if (k == LAT + 2) chk($sformatf("row%0d_pulse", i), hit | miss, 1);
        end
        if (v.resume) begin
            if (!v.exp_hit) chk($sformatf("row%0d_hold_busy", i), busy, 1);
            gap = v.exp_hit ? v.exp_d - 1 : HOLD_CYCLES + v.exp_d - 1;
            check_resume($sformatf("row%0d_ring_timing", i), gap, v.exp_d);
        end
        cur_d = v.exp_d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pcount;
        int bad;
        //           cnt       inj   hit   score lives d  resume
        vecs[0] = '{15'h0080, 1'b0, 1'b1, 1, 3, 3, 1'b1};
        vecs[1] = '{15'h0080, 1'b0, 1'b1, 2, 3, 2, 1'b1};
        vecs[2] = '{15'h0080, 1'b0, 1'b1, 3, 3, 2, 1'b1};
        vecs[3] = '{15'h0100, 1'b0, 1'b0, 3, 2, 2, 1'b1};
        vecs[4] = '{15'h0180, 1'b1, 1'b0, 3, 1, 2, 1'b1};
        vecs[5] = '{15'h0000, 1'b1, 1'b0, 3, 0, 2, 1'b0};
        vecs[6] = '{15'h0080, 1'b0, 1'b1, 1, 3, 3, 1'b1};
        vecs[7] = '{15'h0180, 1'b1, 1'b0, 1, 2, 3, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ring_en", ring_en, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Presses in IDLE do nothing
        @(negedge clk);
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_no_judge", pulses, 0);
        chk("idle_ring_pos", ring_q, 15'h4000);

        // Start: period DIV_INIT, first enable on the last prescaler count
        do_start();
        chk("start_busy", busy, 1);
        chk("start_score", score, 0);
        chk("start_lives", lives, 3);
        chk("start_game_over", game_over, 0);
        check_resume("start_period", DIV_INIT - 1, DIV_INIT);
        cur_d = DIV_INIT;

        for (int i = 0; i < 4; i++) apply_row(i);

        // Bouncing button: never stable long enough to register
        repeat (4) @(negedge clk);
        pcount = pulses;
        for (int b = 0; b < 4; b++) begin
            btn = (b % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("bounce_no_judge", pulses, pcount);
        chk("bounce_busy", busy, 1);
        chk("bounce_lives", lives, 2);

        for (int i = 4; i < 6; i++) apply_row(i);

        // Game over: frozen outputs, presses ignored
        chk("over_flag", game_over, 1);
        chk("over_busy", busy, 0);
        chk("over_score", score, 3);
        repeat (8) @(negedge clk);
        pcount = pulses;
        bad = 0;
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 10) btn = 1'b0;
            if (ring_en !== 1'b0) bad++;
        end
        chk("over_ring_quiet", bad, 0);
        chk("over_no_judge", pulses, pcount);
        chk("over_hold_lives", lives, 0);
        chk("over_hold_flag", game_over, 1);

        // Restart from OVER
        do_start();
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_game_over", game_over, 0);
        chk("restart_busy", busy, 1);
        check_resume("restart_period", DIV_INIT - 1, DIV_INIT);
        cur_d = DIV_INIT;

        for (int i = 6; i < 8; i++) apply_row(i);

        // Asynchronous reset in the middle of HOLD
        @(negedge clk);
        chk("prerst_busy", busy, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_score", score, 0);
        chk("arst_lives", lives, 3);
        chk("arst_hit_miss", hit | miss, 0);
        chk("arst_ring_en", ring_en, 0);
        chk("arst_game_over", game_over, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_ring_pos", ring_q, 15'h4000);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_stop_judge.md
Name: ring_stop_judge

Overview:
- Game-control stage wrapped around the one-hot rotating-light counter in the final project ("stop the light" reaction game).
- Generates the counter's shift-enable pulse from a programmable prescaler.
- Debounces the player button, captures the counter's one-hot position on a press, and judges hit or miss against a target bit.
- Tracks score and lives; each hit speeds the rotation up.

Parameters:
W, 15, width of the one-hot count bus; must match the ring counter.
TARGET, 7, index of the target bit in count (0..W-1).
DIV_INIT, 5000000, clk cycles per ring_en pulse at game start (>=2).
DIV_STEP, 500000, reduction of the divisor on each hit.
DIV_MIN, 1000000, floor for the divisor (>=2, <=DIV_INIT).
DB_CYCLES, 200000, stable cycles required by the button debouncer.
HOLD_CYCLES, 25000000, pause after a miss.
LIVES, 3, lives per game (1..7).
SCORE_W, 8, score width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle synchronous start pulse
btn  in  1  raw asynchronous player button, active-high
count  in  W  one-hot position from the ring counter
ring_en  out  1  one-cycle shift enable to the ring counter
hit  out  1  one-cycle pulse on a judged hit
miss  out  1  one-cycle pulse on a judged miss
score  out  SCORE_W  current score
lives  out  3  remaining lives
game_over  out  1  high while in OVER
busy  out  1  high in RUN, JUDGE or HOLD

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE.
- ring_en=0, hit=0, miss=0, score=0, lives=LIVES, game_over=0, busy=0.
- Prescaler=0, div=DIV_INIT, debouncer level=0, synchroniser flops=0.
- Reset mid-game aborts immediately. No state survives.

Button path:
- btn passes through a 2-flop synchroniser.
- Debounced level takes the synchronised value after it has differed from the current level for DB_CYCLES consecutive cycles. Any bounce restarts the count.
- press is a one-cycle pulse on a 0->1 transition of the debounced level.
- Latency from a clean btn rise to press is 2+DB_CYCLES cycles.
- Releases produce nothing.

Prescaler (active in RUN only):
- Counts 0..div-1 and wraps to 0.
- ring_en=1 for exactly the cycle the count equals div-1.
- ring_en is 0 in all other states.

FSM:
- IDLE: on start, load div=DIV_INIT, score=0, lives=LIVES, prescaler=0, then go to RUN. press is ignored.
- RUN: on press, register cap=count and go to JUDGE.
  - If press coincides with the terminal prescaler count, ring_en is suppressed that cycle, so cap equals the displayed position.
  - start is ignored.
- JUDGE: one cycle.
  - Hit condition: cap is exactly one-hot AND cap[TARGET]=1. A zero or multi-bit cap is a miss.
  - On hit: hit=1; score+1, saturating at all-ones; div = max(div-DIV_STEP, DIV_MIN) with no underflow; prescaler=0; go to RUN.
  - On miss: miss=1; lives-1; if the new lives value is 0, go to OVER, otherwise go to HOLD.
- HOLD: wait HOLD_CYCLES cycles, then clear prescaler and go to RUN.
  - presses are discarded.
  - div, score and lives are unchanged.
- OVER: game_over=1; score and lives hold.
  - On start, re-initialise exactly as from IDLE and go to RUN.
  - presses are ignored.

General rules:
- hit and miss are never asserted together.
- Each is asserted only in the cycle following JUDGE entry: registered outputs, one cycle after cap.
- busy=1 in RUN, JUDGE and HOLD.

Test Plan:
Bench parameters: W=15, TARGET=7, DIV_INIT=4, DIV_STEP=1, DIV_MIN=2, DB_CYCLES=3, HOLD_CYCLES=5, LIVES=3. Bench models the ring counter, starting at count=15'h4000.

1. Assert reset, then start pulse -> ring_en pulses every 4 cycles with 1 cycle high; busy=1; score=0; lives=3.
2. Clean btn rise timed so press lands while count=15'h0080 -> hit pulse; score=1; ring_en period becomes 3. Repeat twice more -> period stays 2 and score=3.
3. press with count=15'h0100 -> miss pulse; lives=2; ring_en low for 5 cycles, then resumes.
4. btn bouncing 1-0-1-0 with 2-cycle pulses -> no press, no judge. A btn held high for 10 cycles -> exactly one press after 5 cycles.
5. Three misses -> lives=0, game_over=1, ring_en stays 0; further btn presses have no effect. Then a start pulse -> score=0, lives=3, period 4.
6. Inject count=15'h0180 at press -> miss. Assert rst_n low mid-HOLD -> all outputs return to reset values within the same cycle, asynchronously.
